// File: rtl/serial_frame_pkg.sv
// Shared types and line levels for the framed serial transmitter.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    // Bits needed for a counter that takes n distinct values 0..n-1, never below 1.
    function automatic int counter_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts clk cycles within one serial bit and flags the last one.
module bit_timer
    import serial_frame_pkg::*;
#(
    parameter  int CLKS_PER_BIT = 4,
    localparam int CW           = counter_width(CLKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          bit_end
);

    logic [CW-1:0] count_reg;

    assign count   = count_reg;
    assign bit_end = en && (count_reg == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count_reg <= '0;
        end else if (bit_end) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out framed transmitter: start, data LSB-first, optional parity, stop.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int   CW      = counter_width(CLKS_PER_BIT);
    localparam int   IW      = counter_width(WIDTH);
    localparam logic ODD_BIT = (PARITY_ODD != 0);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic             parity_reg, parity_next;
    logic             tx_reg, tx_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic [CW-1:0]    timer_count;
    logic             bit_end;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .clr_n  (clr_n),
        .en     (state_reg != IDLE),
        .count  (timer_count),
        .bit_end(bit_end)
    );

    assign din_ready = (state_reg == IDLE);
    assign tx        = tx_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        idx_next    = idx_reg;
        parity_next = parity_reg;
        case (state_reg)
            IDLE: begin
                if (din_valid) begin
                    shift_next  = din;
                    parity_next = (^din) ^ ODD_BIT;
                    state_next  = START;
                end
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (idx_reg == IW'(WIDTH - 1)) begin
                        idx_next   = '0;
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                if (bit_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave registers aligned with the state.
    always_comb begin
        tx_next = LINE_IDLE;
        case (state_next)
            IDLE:    tx_next = LINE_IDLE;
            START:   tx_next = LINE_START;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = parity_next;
            STOP:    tx_next = LINE_STOP;
            default: tx_next = LINE_IDLE;
        endcase
        busy_next = (state_next != IDLE);
        done_next = 1'b0;
        // done marks the last clk of the stop bit: either one more count inside STOP,
        // or the single-cycle stop bit when each bit lasts one clk.
        if (state_reg == STOP && !bit_end && (32'(timer_count) + 1 == CLKS_PER_BIT - 1)) begin
            done_next = 1'b1;
        end
        if (state_reg != STOP && state_next == STOP && CLKS_PER_BIT == 1) begin
            done_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg  <= IDLE;
            shift_reg  <= '0;
            idx_reg    <= '0;
            parity_reg <= 1'b0;
            tx_reg     <= LINE_IDLE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            shift_reg  <= shift_next;
            idx_reg    <= idx_next;
            parity_reg <= parity_next;
            tx_reg     <= tx_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx across four parameter sets sharing one clock.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [7:0] din_a [4];
    logic [3:0] valid_v;
    logic [3:0] ready_v;
    logic [3:0] tx_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u_base (
        .clk(clk), .clr_n(clr_n), .din(din_a[0]), .din_valid(valid_v[0]),
        .din_ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
        .clk(clk), .clr_n(clr_n), .din(din_a[1]), .din_valid(valid_v[1]),
        .din_ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk(clk), .clr_n(clr_n), .din(din_a[2]), .din_valid(valid_v[2]),
        .din_ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u_fast (
        .clk(clk), .clr_n(clr_n), .din(din_a[3]), .din_valid(valid_v[3]),
        .din_ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input int k, input string name);
        check($sformatf("%s tx", name),    32'(tx_v[k]),    32'd1);
        check($sformatf("%s busy", name),  32'(busy_v[k]),  32'd0);
        check($sformatf("%s done", name),  32'(done_v[k]),  32'd0);
        check($sformatf("%s ready", name), 32'(ready_v[k]), 32'd1);
    endtask

    // Called just after the handshake edge; frame bit j is bits[j].
    task automatic check_frame(input int k, input int cpb, input logic [15:0] bits,
                               input int nbits, input string name);
        int total;
        total = nbits * cpb;
        for (int i = 1; i <= total; i++) begin
            @(negedge clk);
            check($sformatf("%s tx c%0d", name, i),   32'(tx_v[k]),   32'(bits[(i-1)/cpb]));
            check($sformatf("%s busy c%0d", name, i), 32'(busy_v[k]), 32'd1);
            check($sformatf("%s done c%0d", name, i), 32'(done_v[k]), (i == total) ? 32'd1 : 32'd0);
            check($sformatf("%s ready c%0d", name, i), 32'(ready_v[k]), 32'd0);
        end
    endtask

    task automatic send(input int k, input logic [7:0] d, input int cpb,
                        input logic [15:0] bits, input int nbits, input string name);
        @(negedge clk);
        din_a[k]   = d;
        valid_v[k] = 1'b1;
        check($sformatf("%s ready pre", name), 32'(ready_v[k]), 32'd1);
        @(posedge clk);
        #1;
        valid_v[k] = 1'b0;
        din_a[k]   = 8'h00;
        check_frame(k, cpb, bits, nbits, name);
        @(negedge clk);
        check_idle(k, $sformatf("%s after", name));
    endtask

    initial begin
        clr_n   = 1'b0;
        valid_v = '0;
        for (int k = 0; k < 4; k++) din_a[k] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) check_idle(k, $sformatf("reset%0d", k));
        clr_n = 1'b1;
        @(negedge clk);
        check_idle(0, "released");

        // Frame bit j at bit position j: start, D0..D7, [parity], stop.
        send(0, 8'hA5, 4, 16'b1101001010,  10, "a5");
        send(1, 8'h07, 4, 16'b11000001110, 11, "even");
        send(2, 8'h07, 4, 16'b10000001110, 11, "odd");
        send(3, 8'h80, 1, 16'b1100000000,  10, "fast");

        // Back-to-back with valid held: din changes while busy must not leak in.
        @(negedge clk);
        din_a[0]   = 8'h01;
        valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        din_a[0] = 8'hFF;
        check_frame(0, 4, 16'b1000000010, 10, "b2b1");
        @(negedge clk);
        check("b2b gap tx",    32'(tx_v[0]),    32'd1);
        check("b2b gap ready", 32'(ready_v[0]), 32'd1);
        check("b2b gap busy",  32'(busy_v[0]),  32'd0);
        @(posedge clk);
        #1;
        valid_v[0] = 1'b0;
        din_a[0]   = 8'h3C;
        check_frame(0, 4, 16'b1111111110, 10, "b2b2");
        @(negedge clk);
        check_idle(0, "b2b after");

        // Abort during data bit 3 (clks 17..20 after the handshake).
        @(negedge clk);
        din_a[0]   = 8'hA5;
        valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        valid_v[0] = 1'b0;
        repeat (18) @(negedge clk);
        check("abort pre tx",   32'(tx_v[0]),   32'd0);
        check("abort pre busy", 32'(busy_v[0]), 32'd1);
        #2;
        clr_n = 1'b0;
        #1;
        check_idle(0, "abort async");
        @(negedge clk);
        check_idle(0, "abort held");
        clr_n = 1'b1;
        send(0, 8'h07, 4, 16'b1000001110, 10, "post");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
